// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants, FSM encoding and vote helper for the UART RX.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    // Tick indices inside one bit period at which the line is sampled
    localparam logic [3:0] SAMPLE_A  = 4'd7;
    localparam logic [3:0] SAMPLE_B  = 4'd8;
    localparam logic [3:0] SAMPLE_C  = 4'd9;
    localparam logic [3:0] LAST_TICK = 4'd15;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_os16_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os16_if
// Brief    : Serial line in, received-byte strobe and status out.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_os16_if;
    import uart_pkg::*;

    logic       rx;
    logic       rx_flag;
    logic [7:0] rx_data;
    logic       frame_err;
    logic       busy;

    // master: the receiver; slave: the line driver / byte consumer
    modport master (
        input  rx,
        output rx_flag,
        output rx_data,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  rx_flag,
        input  rx_data,
        input  frame_err,
        input  busy
    );

endinterface
`default_nettype wire

// File: rtl/uart_rx_os16_baud_tick.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_tick
// Brief    : Divide clk by DIV into a one-cycle oversampling tick.
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  wire logic clk,
    input  wire logic rstn,
    input  wire logic clr,
    output logic      tick
);
    import uart_pkg::*;

    localparam int c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DIV - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    assign tick = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_os16.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_os16
// Brief    : 16x oversampling 8N1 receiver with 3-sample majority vote.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_os16 #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DIV        = CLK_FREQ / (BAUD * OVERSAMPLE)
) (
    input  wire logic       clk,
    input  wire logic       rstn,
    uart_rx_os16_if.master  rx_if
);
    import uart_pkg::*;

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic       w_fall;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       w_tick;
    logic       w_start;
    logic       w_last;
    logic       w_shift_en;
    logic       w_flag_nxt;
    logic       w_ferr_nxt;
    logic       w_vote;
    logic       w_vote_stop;

    logic [3:0] r_ti;
    logic [2:0] r_bit_cnt;
    logic [2:0] r_samp;
    logic [7:0] r_shift;
    logic [7:0] r_data;
    logic       r_flag;
    logic       r_ferr;

    // Flops reset high so an idle line never looks like a start edge
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rx_if.rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_fall = r_prev & ~r_sync2;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rstn (rstn),
        .clr  (w_start),
        .tick (w_tick)
    );

    assign w_last      = w_tick && (r_ti == LAST_TICK);
    assign w_vote      = majority3(r_samp);
    // Stop decision uses the live tick-9 sample alongside the stored 7/8 samples
    assign w_vote_stop = majority3({r_sync2, r_samp[1:0]});

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift_en  = 1'b0;
        w_flag_nxt  = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_state_nxt = START;
                    w_start     = 1'b1;
                end
            end
            START: begin
                if (w_last) begin
                    w_state_nxt = w_vote ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_last) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (w_tick && (r_ti == SAMPLE_C)) begin
                    if (w_vote_stop) begin
                        w_flag_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ti      <= 4'd0;
            r_bit_cnt <= 3'd0;
            r_samp    <= 3'b111;
            r_shift   <= 8'h00;
            r_data    <= 8'h00;
            r_flag    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_flag <= w_flag_nxt;
            r_ferr <= w_ferr_nxt;

            if (w_start) begin
                r_ti      <= 4'd0;
                r_bit_cnt <= 3'd0;
            end else if (w_tick && (r_state != IDLE)) begin
                r_ti <= r_ti + 4'd1;
            end

            if (w_tick) begin
                if (r_ti == SAMPLE_A) r_samp[0] <= r_sync2;
                if (r_ti == SAMPLE_B) r_samp[1] <= r_sync2;
                if (r_ti == SAMPLE_C) r_samp[2] <= r_sync2;
            end

            if (w_shift_en) begin
                r_shift[r_bit_cnt] <= w_vote;
                r_bit_cnt          <= r_bit_cnt + 3'd1;
            end

            if (w_flag_nxt) begin
                r_data <= r_shift;
            end
        end
    end

    assign rx_if.rx_flag   = r_flag;
    assign rx_if.rx_data   = r_data;
    assign rx_if.frame_err = r_ferr;
    assign rx_if.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/uart_rx_os16.md
# uart_rx_os16

16x-oversampling UART byte receiver: the serial-input stage directly upstream of the ASCII terminal editor. It synchronizes the raw serial line, validates start bits, majority-votes each bit and checks the stop bit. Each good byte is delivered to the editor as a one-cycle `rx_flag` strobe with `rx_data`. The format is 8N1, LSB first, and the line idles high.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate.
- `OVERSAMPLE`, default 16: ticks per bit. Fixed at 16; any other value is unsupported.
- `DIV`, default CLK_FREQ/(BAUD*OVERSAMPLE) = 54: clocks per tick, using integer truncation.
- `clk` input, 1 bit: single system clock.
- `rstn` input, 1 bit: reset. Synchronous, active-low.
- `rx` input, 1 bit: asynchronous serial line. The top level ties this to its USB-UART pin named `tx`.
- `rx_flag` output, 1 bit: one-cycle pulse; `rx_data` is valid in the same cycle.
- `rx_data` output, 8 bits: last good byte. Holds its value until the next good byte.
- `frame_err` output, 1 bit: one-cycle pulse when the stop bit is sampled low.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- Input path: `rx` passes through a 2-FF synchronizer, then an edge register. Both synchronizer flops and the edge register reset to 1, so there is no spurious start after reset.
- Tick generator counts 0..DIV-1 and emits `tick` on DIV-1. Its count is cleared on the IDLE->START transition, which phase-aligns ticks to the start edge.
- Tick index `ti` counts 0..15 and increments on `tick`. Samples are taken on ticks 7, 8 and 9; the bit value is the majority of the 3 samples.
- States and transitions:
  - IDLE:
    - A synchronized falling edge (prev=1, now=0) moves to START.
    - On that transition: `ti` <= 0 and the divider is cleared.
  - START:
    - At `ti`=15, if the majority vote is 0, go to DATA with bit count 0.
    - Otherwise it is a false start (glitch); go to IDLE with no output.
  - DATA:
    - At `ti`=15, shift the vote into bit [count] of the shift register (LSB first).
    - After bit 7, go to STOP.
  - STOP:
    - Decide on the tick-9 sample. Do not wait for `ti`=15; this allows back-to-back bytes with baud mismatch.
    - Vote 1: load `rx_data` from the shift register, pulse `rx_flag`, go to IDLE.
    - Vote 0: pulse `frame_err`, go to WAIT_IDLE; `rx_data` is unchanged.
  - WAIT_IDLE: stay until the synchronized line is 1, then go to IDLE. This covers break conditions: no restart on a held-low line.
- `rx_flag` and `frame_err` are never high together, and each lasts exactly one clock.
- Reset while mid-byte discards the partial byte. All state returns to IDLE on the next clock with `rstn` low.

## Timing
- Reset values: `rx_flag`=0, `rx_data`=8'h00, `frame_err`=0, `busy`=0, state=IDLE.
- Bit period is 16*DIV clocks, which is 864 at the defaults (actual rate 115741 baud, +0.47%).
- `busy` rises 1 clock after the synchronized falling edge is seen.
- `rx_flag` is registered. It rises on the clock after the stop-bit tick-9 sample: nominally 9*864 + 10*54 + 3 ≈ 8319 clocks after the pin edge, including 2 synchronizer cycles plus the edge register.
- `busy` falls in the same cycle `rx_flag` rises.
- The next start edge is accepted from the cycle after the return to IDLE.
- Supported sampling tolerance is ±3% total baud mismatch.

## Structure
- Package `uart_pkg` holds:
  - state encoding localparams: IDLE, START, DATA, STOP, WAIT_IDLE (3 bits);
  - `OVERSAMPLE`=16;
  - sample indices 7, 8 and 9;
  - last-tick index 15.
- Sub-module `uart_baud_tick`:
  - parameter `DIV`;
  - ports `clk`, `rstn`, `clr` (synchronous clear) and `tick` (one-cycle pulse).
- The main module holds the synchronizer, FSM, 3-sample vote register, bit counter and shift register.

## Test plan
- Byte 0x41, driven at 864 clocks/bit: exactly one `rx_flag` pulse with `rx_data`=0x41, `frame_err` never high, `rx_flag` about 8319 clocks after the start edge.
- Back-to-back 0x1B, 0x5B, 0x43 with zero idle gap and the driver at +2.5% baud: three `rx_flag` pulses with data 1B, 5B, 43 in order.
- Line low for 200 clocks (less than half a bit), then high: no `rx_flag`, no `frame_err`, `busy` returns to 0 by clock ~870 after the edge.
- Frame 0x00 with the stop bit driven low, then the line held low for 3 bit times, then high: one `frame_err` pulse, no `rx_flag`, `busy` high until 3 clocks after the line goes high, `rx_data` unchanged.
- `rstn` low for 1 clock during data bit 3 of 0xA5, then a fresh 0x3C: `busy`=0 and `rx_data`=0x00 after reset, no pulse for 0xA5, `rx_flag` with `rx_data`=0x3C.
- Single-clock glitch high on `rx` at tick 8 of data bit 2 of 0x00: `rx_data`=0x00, since the majority vote rejects the glitch.
